// File: rtl/sqwave_sched.sv
// sqwave_sched: multi-channel square-wave scheduler with a single-entry
// config shadow. New half-periods land on a period boundary (or at once on
// an idle channel / sync), so a retune never produces a runt pulse.

// One wave channel: half-period register, phase counter and output level.
module sqwave_lane #(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_i,
  input  logic              apply_i,
  input  logic [HALF_W-1:0] new_half_i,
  output logic              idle_o,
  output logic              period_end_o,
  output logic              wave_o,
  output logic              rise_o
);
  logic [HALF_W-1:0] half_q, half_d;
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              out_q, out_d;
  logic              rise_q, rise_d;
  logic              at_top;

  assign at_top       = (cnt_q == half_q - HALF_W'(1));
  assign idle_o       = (half_q == '0);
  assign period_end_o = !idle_o && out_q && at_top;
  assign wave_o       = out_q;
  assign rise_o       = rise_q;

  // Next state: apply beats sync beats normal counting; idle holds low.
  always_comb begin
    half_d = half_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    if (apply_i) begin
      half_d = new_half_i;
      cnt_d  = '0;
      out_d  = 1'b0;
    end else if (sync_i || idle_o) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (at_top) begin
      cnt_d = '0;
      out_d = !out_q;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
    // Registered so it lines up with the first cycle the output reads 1.
    rise_d = out_d && !out_q;
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      half_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
    end
  end
endmodule

module sqwave_sched #(
  parameter int NCH    = 2,
  parameter int HALF_W = 16,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [HALF_W-1:0] cfg_half,
  input  logic              sync,
  output logic [NCH-1:0]    wave_out,
  output logic [NCH-1:0]    wave_rise,
  output logic              busy
);
  logic              sh_full_q, sh_full_d;
  logic [CHW-1:0]    sh_ch_q, sh_ch_d;
  logic [HALF_W-1:0] sh_half_q, sh_half_d;
  logic [NCH-1:0]    apply, idle, pend_end;
  logic              sh_drop, sh_done;

  assign cfg_ready = !sh_full_q;
  assign busy      = sh_full_q;

  // Out-of-range targets are retired without touching any channel.
  assign sh_drop = sh_full_q && (32'(sh_ch_q) >= NCH);
  assign sh_done = sh_drop || (|apply);

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    // Sync forces the pending entry in regardless of where the channel is.
    assign apply[i] = sh_full_q && (32'(sh_ch_q) == i) &&
                      (sync || idle[i] || pend_end[i]);

    sqwave_lane #(.HALF_W(HALF_W)) u_lane (
      .clk          (clk),
      .rst_n        (rst_n),
      .sync_i       (sync),
      .apply_i      (apply[i]),
      .new_half_i   (sh_half_q),
      .idle_o       (idle[i]),
      .period_end_o (pend_end[i]),
      .wave_o       (wave_out[i]),
      .rise_o       (wave_rise[i])
    );
  end

  // Shadow next state; accept only when empty, so load and retire never collide.
  always_comb begin
    sh_full_d = sh_full_q;
    sh_ch_d   = sh_ch_q;
    sh_half_d = sh_half_q;
    if (sh_done) sh_full_d = 1'b0;
    if (cfg_valid && !sh_full_q) begin
      sh_full_d = 1'b1;
      sh_ch_d   = cfg_ch;
      sh_half_d = cfg_half;
    end
  end

  // Shadow registers; reset discards any pending update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_full_q <= 1'b0;
      sh_ch_q   <= '0;
      sh_half_q <= '0;
    end else begin
      sh_full_q <= sh_full_d;
      sh_ch_q   <= sh_ch_d;
      sh_half_q <= sh_half_d;
    end
  end
endmodule

// File: tb/tb_sqwave_sched.sv
// Bench for sqwave_sched: expected rise cycles are queued per channel when a
// config/sync is driven and popped by a negedge monitor on every wave_rise.
module tb_sqwave_sched;
  localparam int NCH = 2;
  localparam int HW  = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [0:0]     cfg_ch;
  logic [HW-1:0]  cfg_half;
  logic           sync;
  logic [NCH-1:0] wave_out;
  logic [NCH-1:0] wave_rise;
  logic           busy;

  sqwave_sched #(.NCH(NCH), .HALF_W(HW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_half(cfg_half), .sync(sync),
    .wave_out(wave_out), .wave_rise(wave_rise), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int  exp_q0[$];
  int  exp_q1[$];
  bit  mon_on[2];
  int  mon_end[2];

  typedef struct {
    int ch;
    int half;
    int lat;     // cycles from apply edge to first rise
    int period;
    int high;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input int ch, input int t);
    if (ch == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
  endtask

  task automatic sb_pop(input int ch);
    int e;
    int sz;
    sz = (ch == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL rise_ch%0d: got rise at cyc %0d expected none", ch, cyc);
    end else begin
      e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check($sformatf("rise_ch%0d", ch), cyc, e);
    end
  endtask

  task automatic sb_empty(input int ch);
    check($sformatf("missing_rises_ch%0d", ch), (ch == 0) ? exp_q0.size() : exp_q1.size(), 0);
  endtask

  // Monitor: every rise inside a channel's window must match the queue head.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (mon_on[i] && cyc < mon_end[i] && wave_rise[i] === 1'b1) sb_pop(i);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_on[0] = 0; mon_on[1] = 0;
    exp_q0.delete(); exp_q1.delete();
    cfg_valid = 0; sync = 0;
    rst_n = 0;
    tick(3);
    rst_n = 1;
    tick(1);
  endtask

  // Drive one write from a negedge; returns the accept edge, ends at cyc==e0.
  task automatic cfg_write(input int ch, input int half, output int e0);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 50) begin tick(1); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL cfg_ready_timeout: got 0 expected 1 (cyc %0d)", cyc);
    end
    cfg_valid = 1; cfg_ch = 1'(ch); cfg_half = HW'(half);
    e0 = cyc + 1;
    tick(1);
    cfg_valid = 0;
  endtask

  initial begin
    int e0, e1, ea, eb, R, R1, S, first, bad;
    rst_n = 0; cfg_valid = 0; cfg_ch = 0; cfg_half = 0; sync = 0;
    vecs[0] = '{0, 3, 3, 6, 3};
    vecs[1] = '{1, 2, 2, 4, 2};
    vecs[2] = '{0, 1, 1, 2, 1};
    vecs[3] = '{1, 5, 5, 10, 5};
    vecs[4] = '{0, 7, 7, 14, 7};

    // Reset state and idle quiet period.
    tick(3);
    check("rst_wave_out", wave_out, 0);
    check("rst_wave_rise", wave_rise, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst_n = 1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick(1);
      if (wave_out !== 0 || wave_rise !== 0 || busy !== 0) bad++;
    end
    check("idle_50_quiet", bad, 0);

    // Table: single channel from disabled -> latency, period, duty.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg_write(vecs[v].ch, vecs[v].half, e0);
      first = e0 + 1 + vecs[v].lat;
      for (int k = 0; k < 3; k++) sb_push(vecs[v].ch, first + k * vecs[v].period);
      mon_end[0] = first + 2 * vecs[v].period + 1;
      mon_end[1] = mon_end[0];
      mon_on[0] = 1; mon_on[1] = 1;
      wait_until(first + vecs[v].high - 1);
      check($sformatf("vec%0d_high_end", v), wave_out[vecs[v].ch], 1);
      wait_until(first + vecs[v].high);
      check($sformatf("vec%0d_low_start", v), wave_out[vecs[v].ch], 0);
      wait_until(mon_end[0]);
      sb_empty(vecs[v].ch);
    end

    // Two channels together, plus ready/busy around an accept.
    do_reset();
    cfg_write(0, 3, ea);
    check("acc_busy", busy, 1);
    check("acc_ready", cfg_ready, 0);
    tick(1);
    check("apply_busy", busy, 0);
    check("apply_ready", cfg_ready, 1);
    cfg_write(1, 2, eb);
    for (int k = 0; k < 4; k++) sb_push(0, ea + 4 + 6 * k);
    for (int k = 0; k < 4; k++) sb_push(1, eb + 3 + 4 * k);
    mon_end[0] = ea + 4 + 18 + 1; mon_end[1] = eb + 3 + 12 + 1;
    mon_on[0] = 1; mon_on[1] = 1;
    wait_until(mon_end[0] > mon_end[1] ? mon_end[0] : mon_end[1]);
    sb_empty(0); sb_empty(1);

    // Retune ch0 5 -> 2 mid-high, then disable at a period-end edge.
    do_reset();
    cfg_write(0, 5, e0);
    R = e0 + 6;
    sb_push(0, R); sb_push(0, R + 7); sb_push(0, R + 11);
    sb_push(0, R + 15); sb_push(0, R + 19);
    mon_end[0] = R + 70; mon_end[1] = R + 70;
    mon_on[0] = 1; mon_on[1] = 1;
    wait_until(R + 1);
    cfg_write(0, 2, e1);
    check("retune_accept_edge", e1, R + 2);
    check("retune_busy", busy, 1);
    wait_until(R + 4);
    check("retune_high_full", wave_out[0], 1);
    check("retune_busy_hold", busy, 1);
    wait_until(R + 5);
    check("retune_fall", wave_out[0], 0);
    check("retune_busy_clear", busy, 0);
    wait_until(R + 6);
    check("retune_low2", wave_out[0], 0);
    wait_until(R + 16);
    cfg_write(0, 0, e1);
    wait_until(R + 20);
    check("dis_last_high", wave_out[0], 1);
    check("dis_busy", busy, 1);
    wait_until(R + 21);
    check("dis_busy_clear", busy, 0);
    bad = 0;
    while (cyc < R + 70) begin
      if (wave_out[0] !== 1'b0) bad++;
      tick(1);
    end
    check("dis_stays_low", bad, 0);
    sb_empty(0);

    // Back-pressure on a second write, then sync phase-align.
    do_reset();
    mon_on[0] = 1; mon_on[1] = 1;
    mon_end[0] = 1000; mon_end[1] = 1000;
    cfg_write(0, 3, ea);
    cfg_valid = 1; cfg_ch = 1'(1); cfg_half = HW'(5);
    check("bp_ready_low", cfg_ready, 0);
    tick(1);
    check("bp_ready_back", cfg_ready, 1);
    tick(1);
    cfg_valid = 0;
    check("bp_second_busy", busy, 1);
    S = ea + 20;
    sb_push(0, ea + 4); sb_push(0, ea + 10); sb_push(0, ea + 16);
    sb_push(0, S + 3); sb_push(0, S + 9); sb_push(0, S + 15);
    sb_push(1, ea + 8); sb_push(1, ea + 18);
    sb_push(1, S + 5); sb_push(1, S + 15);
    mon_end[0] = S + 16; mon_end[1] = S + 16;
    wait_until(S - 1);
    sync = 1;
    tick(1);
    sync = 0;
    check("sync_all_low", wave_out, 0);
    wait_until(S + 3);
    check("sync_ch0_up", wave_out[0], 1);
    wait_until(S + 5);
    check("sync_ch1_up", wave_out[1], 1);
    wait_until(S + 16);
    sb_empty(0); sb_empty(1);

    // Reset while a retune of ch1 is pending.
    do_reset();
    cfg_write(1, 4, e0);
    R1 = e0 + 5;
    sb_push(1, R1);
    mon_end[0] = R1 + 60; mon_end[1] = R1 + 60;
    mon_on[0] = 1; mon_on[1] = 1;
    wait_until(R1 + 1);
    cfg_write(1, 7, e1);
    check("mid_busy", busy, 1);
    rst_n = 0;
    tick(1);
    check("mid_rst_wave", wave_out, 0);
    check("mid_rst_rise", wave_rise, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cfg_ready, 1);
    tick(1);
    rst_n = 1;
    bad = 0;
    while (cyc < R1 + 60) begin
      tick(1);
      if (wave_out !== 0 || busy !== 0) bad++;
    end
    check("mid_rst_ch1_disabled", bad, 0);
    sb_empty(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sqwave_sched.md
# sqwave_sched

Programmable multi-channel square-wave scheduler. It derives NCH independent square waves from one system clock, each with a run-time half-period in clock cycles. Channels are configured through a valid/ready write port. Updates are applied glitch-free at period boundaries, and a sync pulse phase-aligns all channels. It replaces free-running `always #d clk = ~clk` stimulus generators with a synthesizable clock-enable/strobe source for downstream logic and benches.

## Interface
- NCH, 2, number of wave channels (1..8)
- HALF_W, 16, width of the half-period count
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config port can accept; high when the shadow register is empty
- cfg_ch  in  $clog2(NCH) (min 1)  target channel; values ≥ NCH are accepted and dropped
- cfg_half  in  HALF_W  new half-period in cycles; 0 = disable channel
- sync  in  1  single-cycle phase-align strobe for all channels
- wave_out  out  NCH  square-wave outputs
- wave_rise  out  NCH  one-cycle strobe, high in the cycle wave_out[i] first reads 1
- busy  out  1  high while a config update is pending

## Operation
- Per-channel state: `half[i]` (HALF_W), `cnt[i]` (HALF_W), `out[i]`.
- Shared state: one shadow entry {ch, half, full}.
- Reset values:
  - wave_out = 0, wave_rise = 0, busy = 0, cfg_ready = 1
  - all half = 0 (disabled), cnt = 0
  - shadow empty
- Accept: on an edge with cfg_valid && cfg_ready, the shadow loads {cfg_ch, cfg_half} and full is set. cfg_ready = !full. busy = full.
- Running channel (half[i] ≠ 0):
  - Each edge: if cnt == half−1, then cnt ← 0 and out toggles; else cnt ← cnt+1.
  - High time = low time = half cycles; period = 2·half.
- Disabled channel (half[i] == 0): cnt held 0, out held 0.
- Apply condition for a pending shadow targeting channel c:
  - Channel c is disabled: apply on the first edge with full set.
  - Channel c is running: apply on the period-end edge (out == 1 && cnt == half−1).
  - On apply: half[c] ← shadow.half, cnt[c] ← 0, out[c] ← 0, shadow cleared.
  - Result: no runt pulse; the new setting starts with a full low phase.
- A shadow with ch ≥ NCH is cleared on the next edge with no effect.
- Sync: on an edge with sync = 1, every channel sets cnt ← 0 and out ← 0, keeping its half. A pending shadow is applied on that same edge, regardless of target state.
- Arithmetic: cnt compares against half−1 in HALF_W bits. Max half = 2^HALF_W−1, no overflow.

## Timing
- Config latency for a disabled channel: accept edge E0, apply edge E1, cfg_ready high after E1, first wave_out rise after edge E1+half.
- Config latency for a running channel: applied on the first period-end edge after E0. Worst case is 2·half_old cycles.
- cfg_ready drops the cycle after acceptance. Back-to-back writes are therefore serialized through the single shadow.
- wave_rise[i] is registered and coincident with the first cycle wave_out[i] = 1. It is never asserted for a disabled channel.
- Simultaneous events:
  - sync + period-end on the same edge: sync wins; out = 0 and cnt = 0.
  - sync + accept on the same edge: the shadow loads, is not yet applied, and applies normally afterwards.
  - Period-end + accept on the same edge: the new entry waits for the next apply condition.
- rst_n low mid-operation: all outputs are 0 on the next edge and the pending update is discarded. Reset has priority over sync and cfg.

## Test plan
- **Reset:** hold rst_n = 0 for 3 cycles. Required: wave_out = 0, wave_rise = 0, busy = 0, cfg_ready = 1. With no config written, outputs stay 0 for 50 cycles.
- **Basic waves:** write ch0 half = 3, then ch1 half = 2. Required:
  - wave_out[0] has a period of 6 cycles at 50% duty, with wave_rise[0] every 6 cycles.
  - wave_out[1] has a period of 4 cycles.
  - Rise latency from the apply edge equals half.
- **Glitch-free retune:** with ch0 half = 5 running, write half = 2 mid-high-phase. Required:
  - The current high phase completes its full 5 cycles.
  - Low for 2, then period 4.
  - busy is high until the period-end edge.
- **Disable:** with ch0 running, write half = 0. Required: the output falls at period end and stays 0. wave_rise[0] is never asserted again.
- **Sync and back-pressure:** run ch0 half = 3 and ch1 half = 5, then pulse sync. Required: both outputs are 0 on the next edge and both rise exactly 3 and 5 cycles later. A second cfg_valid while busy sees cfg_ready = 0 and is not lost once ready returns.
- **Reset mid-update:** write ch1 half = 7 while ch1 runs half = 4, then assert rst_n = 0 before period end. Required: all outputs 0, shadow dropped, ch1 disabled after reset release.
